adc_reader: RTL and testbench
=============================

// Module: adc_reader
// PURPOSE
// SPI receiver for the dual-channel 14-bit ECG front-end ADC (LTC1407A-1 protocol); the input-side counterpart of the DAC driver.
// Generates AD_CONV and SPI_SCK from CLK_50M, shifts in both channels MSB-first from SPI_MISO and presents them as
// two's-complement words with a one-cycle valid strobe. Feeds the filtering chain; shares the SPI bus with the DAC.
// PARAMETERS
// SCK_HALF    4    SPI_SCK half-period in CLK_50M cycles (4 -> 160 ns SCK, 6.25 MHz); legal range 1..255
// FRAME_SCK   34   SCK cycles per frame after the AD_CONV pulse
// DATA_W      14   bits per channel
// PORTS
// CLK_50M      in   1       system clock, 50 MHz; all logic on rising edge
// RESET        in   1       asynchronous, active-high reset
// startEnable  in   1       level; while high, frames run back-to-back
// SPI_MISO     in   1       serial data from ADC, valid on SCK rising edge
// SPI_SCK      out  1       SPI clock, idles low
// AD_CONV      out  1       conversion strobe, high for one SCK period per frame
// Vadc_a       out  DATA_W  channel A sample, two's complement, held until next valid
// Vadc_b       out  DATA_W  channel B sample, two's complement, held until next valid
// dataValid    out  1       one-cycle pulse when Vadc_a/Vadc_b update
// busy         out  1       high in any state other than IDLE
// BEHAVIOUR
// - Reset (async, immediate): state IDLE; SPI_SCK=0, AD_CONV=0, Vadc_a=0, Vadc_b=0, dataValid=0, busy=0; divider,
//   bit counter and shift register cleared; firstFrame flag set.
// - FSM: IDLE -> CONV -> SHIFT -> DONE -> (CONV if startEnable else IDLE).
// - IDLE: SCK low, AD_CONV low. startEnable sampled high -> CONV on next cycle.
// - CONV: AD_CONV=1 for exactly 2*SCK_HALF cycles, SCK held low; then SHIFT.
// - SHIFT: SCK low for SCK_HALF cycles, then high SCK_HALF cycles, repeated FRAME_SCK times; SCK ends low.
//   SPI_MISO is registered on the same CLK_50M edge that drives SCK 0->1. Rising edges numbered 1..34:
//   1-2 ignored (hi-Z); 3-16 channel A bits 13..0; 17-18 ignored; 19-32 channel B bits 13..0; 33-34 ignored.
// - DONE: one cycle. If firstFrame is clear: Vadc_a/Vadc_b load shift-register contents and dataValid=1 this cycle.
//   If firstFrame is set: outputs unchanged, no pulse, firstFrame cleared (ADC returns the previous conversion,
//   so the first frame after reset carries no valid sample).
// - Frame length = 2*SCK_HALF + 2*SCK_HALF*FRAME_SCK + 1 cycles (281 at defaults); back-to-back period identical.
// - startEnable falling mid-frame: current frame completes (including dataValid), then IDLE. No abort path.
// - startEnable re-asserted in DONE: direct DONE->CONV, no IDLE cycle.
// - Ignored bit positions never affect outputs, whatever value (0/1/X) MISO carries.
// - busy=1 in CONV, SHIFT, DONE. Vadc outputs change only in DONE; never partially updated.
// - Counters: divider counts 0..SCK_HALF-1 and wraps; bit counter 0..FRAME_SCK, 6 bits.
// TESTING
// 1 Reset: hold RESET 5 cycles -> all outputs 0, SPI_SCK low; release with startEnable=0 -> no activity for 1000 cycles.
// 2 Two frames, ADC model drives A=14'h1ABC, B=14'h2001 -> AD_CONV width 8 cycles, 34 SCK pulses of 160 ns;
//   frame 1 no dataValid; frame 2 dataValid at cycle 562 after start, Vadc_a=14'h1ABC, Vadc_b=14'h2001.
// 3 Hi-Z bits driven 1 at edges 1,2,17,18,33,34 with A=14'h0000, B=14'h3FFF -> Vadc_a=0, Vadc_b=14'h3FFF.
// 4 startEnable dropped at SCK edge 10 of frame 3 -> frame completes, dataValid pulses, then IDLE, busy=0.
// 5 RESET asserted at SCK edge 20 -> outputs 0 within same cycle; restart: next frame again suppressed (firstFrame).
// 6 SCK_HALF=1 continuous run -> SCK period 2 cycles, frame 71 cycles, samples captured identically to test 2.

Source files
------------

// File: rtl/adc_reader.sv
// SPI receiver for a dual-channel 14-bit ADC (LTC1407A-1 framing): generates AD_CONV and SPI_SCK,
// shifts both channels in MSB-first and presents them as two's-complement words with a valid strobe.
module adc_reader #(
    parameter int SCK_HALF  = 4,
    parameter int FRAME_SCK = 34,
    parameter int DATA_W    = 14
) (
    input  logic              CLK_50M,
    input  logic              RESET,
    input  logic              startEnable,
    input  logic              SPI_MISO,
    output logic              SPI_SCK,
    output logic              AD_CONV,
    output logic [DATA_W-1:0] Vadc_a,
    output logic [DATA_W-1:0] Vadc_b,
    output logic              dataValid,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

    localparam logic [7:0] DIV_LAST  = 8'(SCK_HALF - 1);
    localparam logic [5:0] LAST_EDGE = 6'(FRAME_SCK);
    localparam logic [5:0] A_FIRST   = 6'd3;
    localparam logic [5:0] A_LAST    = 6'(DATA_W + 2);
    localparam logic [5:0] B_FIRST   = 6'(DATA_W + 5);
    localparam logic [5:0] B_LAST    = 6'(2 * DATA_W + 4);

    state_t            state, state_nx;
    logic [7:0]        div;
    logic [5:0]        bit_cnt;
    logic [DATA_W-1:0] shift_a, shift_b;
    logic              first_frame;
    logic              div_wrap, sck_rise, frame_end;
    logic [5:0]        edge_num;

    always_ff @(posedge CLK_50M or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_nx  = state;
        div_wrap  = (div == DIV_LAST);
        edge_num  = bit_cnt + 6'd1;
        sck_rise  = (state == SHIFT) && div_wrap && !SPI_SCK;
        frame_end = (state == SHIFT) && div_wrap && SPI_SCK && (bit_cnt == LAST_EDGE);
        AD_CONV   = (state == CONV);
        busy      = (state != IDLE);
        unique case (state)
            IDLE:  if (startEnable) state_nx = CONV;
            CONV:  if (div_wrap && bit_cnt[0]) state_nx = SHIFT;
            SHIFT: if (frame_end) state_nx = DONE;
            DONE:  state_nx = startEnable ? CONV : IDLE;
        endcase
    end

    // CONV reuses the divider and bit 0 of the bit counter to time its two SCK half-periods.
    always_ff @(posedge CLK_50M or posedge RESET) begin
        if (RESET) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            div         <= '0;
            bit_cnt     <= '0;
            SPI_SCK     <= 1'b0;
            shift_a     <= '0;
            shift_b     <= '0;
            Vadc_a      <= '0;
            Vadc_b      <= '0;
            dataValid   <= 1'b0;
            first_frame <= 1'b1;
        end else begin
            dataValid <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    div     <= '0;
                    bit_cnt <= '0;
                    SPI_SCK <= 1'b0;
                    if (state == DONE) first_frame <= 1'b0;
                end
                CONV: begin
                    if (div_wrap) begin
                        div     <= '0;
                        bit_cnt <= bit_cnt[0] ? 6'd0 : 6'd1;
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                SHIFT: begin
                    if (div_wrap) begin
                        div     <= '0;
                        SPI_SCK <= ~SPI_SCK;
                    end else begin
                        div <= div + 8'd1;
                    end
                    if (sck_rise) begin
                        bit_cnt <= edge_num;
                        if (edge_num >= A_FIRST && edge_num <= A_LAST)
                            shift_a <= {shift_a[DATA_W-2:0], SPI_MISO};
                        if (edge_num >= B_FIRST && edge_num <= B_LAST)
                            shift_b <= {shift_b[DATA_W-2:0], SPI_MISO};
                    end
                    // The first frame after reset returns a stale conversion and is discarded.
                    if (frame_end && !first_frame) begin
                        Vadc_a    <= shift_a;
                        Vadc_b    <= shift_b;
                        dataValid <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_reader.sv
// Bench for adc_reader: an ADC model serves frames, a scoreboard compares each dataValid event
// with the frame that was sent; a slow (SCK_HALF=4) and a fast (SCK_HALF=1) instance are exercised.
module tb_adc_reader;

    typedef struct {logic [13:0] a; logic [13:0] b;} frame_t;
    typedef struct {int cyc; int frame; logic [13:0] a; logic [13:0] b;} obs_t;
    typedef struct {logic [13:0] a; logic [13:0] b; int fill; logic [13:0] ea; logic [13:0] eb;} vec_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // slow instance (_s) and fast instance (_f)
    logic        rst_s, en_s, sck_s, ad_s, dv_s, busy_s;
    logic        miso_s = 1'b0;
    logic [13:0] va_s, vb_s;
    logic        rst_f, en_f, sck_f, ad_f, dv_f, busy_f;
    logic        miso_f = 1'b0;
    logic [13:0] va_f, vb_f;

    adc_reader #(.SCK_HALF(4), .FRAME_SCK(34), .DATA_W(14)) u_slow (
        .CLK_50M(clk), .RESET(rst_s), .startEnable(en_s), .SPI_MISO(miso_s), .SPI_SCK(sck_s),
        .AD_CONV(ad_s), .Vadc_a(va_s), .Vadc_b(vb_s), .dataValid(dv_s), .busy(busy_s));

    adc_reader #(.SCK_HALF(1), .FRAME_SCK(34), .DATA_W(14)) u_fast (
        .CLK_50M(clk), .RESET(rst_f), .startEnable(en_f), .SPI_MISO(miso_f), .SPI_SCK(sck_f),
        .AD_CONV(ad_f), .Vadc_a(va_f), .Vadc_b(vb_f), .dataValid(dv_f), .busy(busy_f));

    // ADC model knobs: sample values and what to drive on hi-Z positions (0, 1, random)
    logic [13:0] a_s, b_s, a_f, b_f;
    int          fill_s, fill_f;
    frame_t      sent_s[$], sent_f[$];
    obs_t        obs_s[$], obs_f[$];

    function automatic logic adc_bit(frame_t fr, int fill, int k);
        if (k >= 3 && k <= 16)  return fr.a[16 - k];
        if (k >= 19 && k <= 32) return fr.b[32 - k];
        if (fill == 0) return 1'b0;
        if (fill == 1) return 1'b1;
        return 1'($urandom);
    endfunction

    // MISO for edge k is presented after SCK falling edge k-1 (or at AD_CONV for k=1)
    frame_t cur_s, cur_f;
    int     k_s = 0, k_f = 0;
    always @(posedge ad_s or negedge sck_s) begin
        if (ad_s) begin
            cur_s.a = a_s; cur_s.b = b_s; sent_s.push_back(cur_s); k_s = 1;
        end else k_s++;
        miso_s = adc_bit(cur_s, fill_s, k_s);
    end
    always @(posedge ad_f or negedge sck_f) begin
        if (ad_f) begin
            cur_f.a = a_f; cur_f.b = b_f; sent_f.push_back(cur_f); k_f = 1;
        end else k_f++;
        miso_f = adc_bit(cur_f, fill_f, k_f);
    end

    always @(negedge clk) begin
        obs_t o;
        if (dv_s) begin
            o.cyc = cyc; o.frame = sent_s.size(); o.a = va_s; o.b = vb_s; obs_s.push_back(o);
        end
        if (dv_f) begin
            o.cyc = cyc; o.frame = sent_f.size(); o.a = va_f; o.b = vb_f; obs_f.push_back(o);
        end
    end

    int n_pass = 0, n_checks = 0;
    int rd[2], base[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic int obs_cnt(bit fast);
        return fast ? obs_f.size() : obs_s.size();
    endfunction

    task automatic reset_dut(input bit fast);
        if (fast) begin rst_f = 1'b1; en_f = 1'b0; end
        else      begin rst_s = 1'b1; en_s = 1'b0; end
        repeat (5) @(negedge clk);
        base[fast] = fast ? sent_f.size() : sent_s.size();
        rd[fast]   = obs_cnt(fast);
        if (fast) rst_f = 1'b0; else rst_s = 1'b0;
    endtask

    task automatic wait_obs(input bit fast, input int budget, input string name, output bit ok);
        int n = 0;
        while (n < budget && obs_cnt(fast) <= rd[fast]) begin @(negedge clk); n++; end
        ok = obs_cnt(fast) > rd[fast];
        check({name, "_valid_seen"}, 32'(ok), 32'd1);
    endtask

    // compare next observed sample with the frame the ADC model sent
    task automatic check_obs(input bit fast, input string name, input int exp_rel, output obs_t o);
        frame_t fr;
        o  = fast ? obs_f[rd[fast]] : obs_s[rd[fast]];
        rd[fast]++;
        fr = fast ? sent_f[o.frame - 1] : sent_s[o.frame - 1];
        if (exp_rel > 0) check({name, "_frame"}, 32'(o.frame - base[fast]), 32'(exp_rel));
        else             check({name, "_not_first"}, 32'((o.frame - base[fast]) >= 2), 32'd1);
        check({name, "_a"}, 32'(o.a), 32'(fr.a));
        check({name, "_b"}, 32'(o.b), 32'(fr.b));
    endtask

    task automatic wait_idle(input bit fast, input int budget, input string name);
        int n = 0;
        while (n < budget && (fast ? busy_f : busy_s)) begin @(negedge clk); n++; end
        check({name, "_busy"}, 32'(fast ? busy_f : busy_s), 32'd0);
    endtask

    task automatic wait_frames(input bit fast, input int rel, input string name);
        int n = 0;
        while (n < 2000 && ((fast ? sent_f.size() : sent_s.size()) - base[fast]) < rel) begin
            @(negedge clk); n++;
        end
        check({name, "_frame_start"}, 32'((fast ? sent_f.size() : sent_s.size()) - base[fast]), 32'(rel));
    endtask

    task automatic wait_sck_rises(input int count, input string name);
        int n = 0, r = 0;
        logic prev = sck_s;
        while (n < 2000 && r < count) begin
            @(negedge clk); n++;
            if (sck_s && !prev) r++;
            prev = sck_s;
        end
        check({name, "_sck_edges"}, 32'(r), 32'(count));
    endtask

    vec_t vecs[5];

    initial begin
        int   t0, act, rises, highs, bad, last_rise, width;
        bit   ok;
        logic prev;
        obs_t o, p;

        vecs[0] = '{14'h0000, 14'h3FFF, 1, 14'h0000, 14'h3FFF};
        vecs[1] = '{14'h3FFF, 14'h0000, 1, 14'h3FFF, 14'h0000};
        vecs[2] = '{14'h2000, 14'h1FFF, 0, 14'h2000, 14'h1FFF};
        vecs[3] = '{14'h0001, 14'h2AAA, 2, 14'h0001, 14'h2AAA};
        vecs[4] = '{14'h1555, 14'h0800, 1, 14'h1555, 14'h0800};

        rst_s = 1'b1; rst_f = 1'b1; en_s = 1'b0; en_f = 1'b0;
        a_s = '0; b_s = '0; a_f = '0; b_f = '0; fill_s = 0; fill_f = 0;

        // reset state, then no activity while startEnable stays low
        repeat (5) @(negedge clk);
        check("reset_ctrl", {28'd0, sck_s, ad_s, dv_s, busy_s}, 32'd0);
        check("reset_vadc_a", 32'(va_s), 32'd0);
        check("reset_vadc_b", 32'(vb_s), 32'd0);
        base[0] = sent_s.size(); rd[0] = obs_s.size();
        rst_s = 1'b0;
        act = 0;
        repeat (1000) begin @(negedge clk); act += int'(sck_s | ad_s | busy_s | dv_s); end
        check("idle_activity", 32'(act), 32'd0);

        // two frames with A=1ABC, B=2001: timing of AD_CONV and SCK, suppressed first frame
        a_s = 14'h1ABC; b_s = 14'h2001; fill_s = 0;
        en_s = 1'b1; t0 = cyc;
        width = 0;
        while (!ad_s && width < 10) begin @(negedge clk); width++; end
        width = 0;
        while (ad_s && width < 50) begin @(negedge clk); width++; end
        check("adconv_width", 32'(width), 32'd8);
        rises = 0; highs = 0; bad = 0; last_rise = -1; prev = 1'b0;
        for (int i = 0; i < 272; i++) begin
            if (sck_s && !prev) begin
                if (last_rise >= 0 && cyc - last_rise != 8) bad++;
                last_rise = cyc; rises++;
            end
            highs += int'(sck_s);
            prev = sck_s;
            @(negedge clk);
        end
        check("sck_rises", 32'(rises), 32'd34);
        check("sck_high_cycles", 32'(highs), 32'd136);
        check("sck_period_bad", 32'(bad), 32'd0);
        check("first_frame_no_valid", 32'(obs_s.size() - rd[0]), 32'd0);
        wait_obs(0, 600, "two_frames", ok);
        if (ok) begin
            check_obs(0, "two_frames", 2, o);
            check("valid_cycle", 32'(o.cyc - t0), 32'd562);
        end
        en_s = 1'b0;
        wait_idle(0, 300, "two_frames_end");

        // table vectors: hi-Z fill patterns never reach the outputs
        foreach (vecs[i]) begin
            reset_dut(0);
            a_s = vecs[i].a; b_s = vecs[i].b; fill_s = vecs[i].fill;
            en_s = 1'b1;
            wait_obs(0, 700, $sformatf("vec%0d", i), ok);
            if (ok) begin
                o = obs_s[rd[0]]; rd[0]++;
                check($sformatf("vec%0d_frame", i), 32'(o.frame - base[0]), 32'd2);
                check($sformatf("vec%0d_a", i), 32'(o.a), 32'(vecs[i].ea));
                check($sformatf("vec%0d_b", i), 32'(o.b), 32'(vecs[i].eb));
            end
            en_s = 1'b0;
            wait_idle(0, 300, $sformatf("vec%0d_end", i));
        end

        // startEnable dropped at SCK edge 10 of frame 3: frame completes, then idle
        reset_dut(0);
        a_s = 14'($urandom); b_s = 14'($urandom); fill_s = 2;
        en_s = 1'b1;
        wait_obs(0, 700, "drop_f2", ok);
        if (ok) check_obs(0, "drop_f2", 2, o);
        wait_frames(0, 3, "drop");
        wait_sck_rises(10, "drop");
        en_s = 1'b0;
        wait_obs(0, 300, "drop_f3", ok);
        if (ok) check_obs(0, "drop_f3", 3, o);
        wait_idle(0, 3, "drop_idle");
        repeat (600) @(negedge clk);
        check("drop_no_more_frames", 32'(sent_s.size() - base[0]), 32'd3);
        check("drop_no_more_valid", 32'(obs_s.size() - rd[0]), 32'd0);

        // RESET at SCK edge 20: immediate clear, then first frame suppressed again
        reset_dut(0);
        a_s = 14'h1ABC; b_s = 14'h2001; fill_s = 1;
        en_s = 1'b1;
        wait_obs(0, 700, "rst_pre", ok);
        if (ok) check_obs(0, "rst_pre", 2, o);
        wait_frames(0, 3, "rst");
        wait_sck_rises(20, "rst");
        rst_s = 1'b1;
        #1;
        check("rst_async_ctrl", {28'd0, sck_s, ad_s, dv_s, busy_s}, 32'd0);
        check("rst_async_a", 32'(va_s), 32'd0);
        check("rst_async_b", 32'(vb_s), 32'd0);
        @(negedge clk);
        reset_dut(0);
        a_s = 14'($urandom); b_s = 14'($urandom);
        en_s = 1'b1;
        wait_obs(0, 700, "rst_post", ok);
        if (ok) check_obs(0, "rst_post", 2, o);
        en_s = 1'b0;
        wait_idle(0, 300, "rst_post_end");

        // fast instance: SCK period 2 cycles, frame 71 cycles
        reset_dut(1);
        a_f = 14'h1ABC; b_f = 14'h2001; fill_f = 0;
        en_f = 1'b1; t0 = cyc;
        wait_obs(1, 200, "fast_first", ok);
        if (ok) begin
            check_obs(1, "fast_first", 2, o);
            check("fast_valid_cycle", 32'(o.cyc - t0), 32'd142);
            check("fast_vadc_a", 32'(o.a), 32'h1ABC);
            check("fast_vadc_b", 32'(o.b), 32'h2001);
        end
        width = 0;
        while (!ad_f && width < 80) begin @(negedge clk); width++; end
        while (ad_f && width < 160) begin @(negedge clk); width++; end
        rises = 0; highs = 0; prev = 1'b0;
        for (int i = 0; i < 68; i++) begin
            if (sck_f && !prev) rises++;
            highs += int'(sck_f);
            prev = sck_f;
            @(negedge clk);
        end
        check("fast_sck_rises", 32'(rises), 32'd34);
        check("fast_sck_high", 32'(highs), 32'd34);

        // randomized back-to-back frames on the fast instance
        p = o;
        for (int i = 0; i < 20; i++) begin
            a_f = 14'($urandom); b_f = 14'($urandom); fill_f = 2;
            wait_obs(1, 200, $sformatf("rand%0d", i), ok);
            if (!ok) break;
            check_obs(1, $sformatf("rand%0d", i), 0, o);
            check($sformatf("rand%0d_period", i), 32'(o.cyc - p.cyc), 32'd71);
            p = o;
        end
        en_f = 1'b0;
        wait_idle(1, 100, "fast_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
